// File: rtl/tc_acc_buffer.sv
// Per-lane tile accumulator behind tc_array: sums K-step partial-result vectors
// with saturation and parks each finished tile in a one-entry valid/ready output register.
module tc_acc_buffer #(
  parameter int unsigned TILE_M    = 4,
  parameter int unsigned DW_DATA   = 8,
  parameter int unsigned DW_ACC    = 20,
  parameter int unsigned MAX_KSTEP = 64,
  parameter int unsigned DW_CNT    = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TILE_M*DW_DATA-1:0]  in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [TILE_M*DW_ACC-1:0]   out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW_CNT-1:0]          out_ksteps,
  output logic                       out_sat,
  output logic                       out_forced
);

  typedef logic [TILE_M-1:0][DW_ACC-1:0] acc_vec_t;

  localparam logic [DW_CNT-1:0] KMAX = DW_CNT'(MAX_KSTEP);

  acc_vec_t          acc_q, acc_d, sum;
  logic [DW_ACC:0]   wide [TILE_M];
  logic [TILE_M-1:0] lane_sat;
  logic [DW_CNT-1:0] kcnt_q, kcnt_d, kcnt_inc;
  logic              sat_q, sat_d;
  logic              beat_sat, accept, close;

  acc_vec_t          od_q, od_d;
  logic              ov_q, ov_d;
  logic [DW_CNT-1:0] ks_q, ks_d;
  logic              osat_q, osat_d;
  logic              ofrc_q, ofrc_d;

  // kcnt==0 marks a fresh tile, so stale accumulator contents are never summed in.
  always_comb begin
    for (int unsigned i = 0; i < TILE_M; i++) begin
      wide[i]     = (DW_ACC+1)'(in_data[i*DW_DATA +: DW_DATA])
                  + ((kcnt_q == '0) ? '0 : {1'b0, acc_q[i]});
      lane_sat[i] = wide[i][DW_ACC];
      sum[i]      = lane_sat[i] ? '1 : wide[i][DW_ACC-1:0];
    end
  end

  always_comb begin
    in_ready = ~ov_q | out_ready;
    accept   = in_valid & in_ready;
    beat_sat = |lane_sat;
    kcnt_inc = kcnt_q + DW_CNT'(1);
    close    = accept & (in_last | (kcnt_inc == KMAX));

    acc_d  = acc_q;
    kcnt_d = kcnt_q;
    sat_d  = sat_q;
    od_d   = od_q;
    ov_d   = ov_q;
    ks_d   = ks_q;
    osat_d = osat_q;
    ofrc_d = ofrc_q;

    if (ov_q & out_ready)
      ov_d = 1'b0;

    if (accept) begin
      if (close) begin
        acc_d  = '0;
        kcnt_d = '0;
        sat_d  = 1'b0;
        od_d   = sum;
        ov_d   = 1'b1;
        ks_d   = kcnt_inc;
        osat_d = sat_q | beat_sat;
        ofrc_d = ~in_last;
      end else begin
        acc_d  = sum;
        kcnt_d = kcnt_inc;
        sat_d  = sat_q | beat_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      kcnt_q <= '0;
      sat_q  <= 1'b0;
      od_q   <= '0;
      ov_q   <= 1'b0;
      ks_q   <= '0;
      osat_q <= 1'b0;
      ofrc_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      kcnt_q <= kcnt_d;
      sat_q  <= sat_d;
      od_q   <= od_d;
      ov_q   <= ov_d;
      ks_q   <= ks_d;
      osat_q <= osat_d;
      ofrc_q <= ofrc_d;
    end
  end

  assign out_data   = od_q;
  assign out_valid  = ov_q;
  assign out_ksteps = ks_q;
  assign out_sat    = osat_q;
  assign out_forced = ofrc_q;

endmodule
